// File: rtl/lcd_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_ctrl
// HD44780-compatible character-LCD write controller. Each accepted byte is
// driven onto RS/DATA, held for SETUP_CYC cycles, strobed with EN for
// EN_HIGH_CYC cycles, then followed by an execution wait (CLEAR_CYC for the
// slow clear/home instructions, EXEC_CYC otherwise) before the next request is
// accepted. The panel is write-only, so RW is tied low.
//
// Optional build macro: LCD_INIT_EN
//   When defined, the controller waits POWERON_CYC cycles after reset and then
//   issues the instruction bytes 38h, 0Ch, 01h, 06h on its own before it
//   starts accepting requests. When undefined, firmware does the panel setup.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   cmd_valid_i  request valid
//   cmd_rs_i     0 = instruction register, 1 = data register
//   cmd_data_i   byte to write
//   cmd_ready_o  controller can accept a request
//   lcd_on_o     panel power/backlight enable
//   lcd_en_o     LCD EN strobe
//   lcd_rs_o     LCD RS
//   lcd_rw_o     LCD RW, always 0
//   lcd_data_o   LCD DB[7:0]
// -----------------------------------------------------------------------------
module lcd_ctrl #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned EN_HIGH_CYC = 12,
    parameter int unsigned EXEC_CYC    = 2000,
    parameter int unsigned CLEAR_CYC   = 82000,
    parameter int unsigned POWERON_CYC = 750000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    input  logic       cmd_rs_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    output logic       lcd_on_o,
    output logic       lcd_en_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic [7:0] lcd_data_o
);

    localparam int unsigned MAX_AB  = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
    localparam int unsigned MAX_CD  = (EXEC_CYC > CLEAR_CYC) ? EXEC_CYC : CLEAR_CYC;
    localparam int unsigned MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned MAX_CYC = (MAX_ABC > POWERON_CYC) ? MAX_ABC : POWERON_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    // Counter reload values: each phase lasts N cycles, so it counts N-1 .. 0.
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 32'd1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_HIGH_CYC - 32'd1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 32'd1);
    localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(CLEAR_CYC - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        INIT     = 3'd1,
        IDLE     = 3'd2,
        SETUP    = 3'd3,
        PULSE    = 3'd4,
        EXEC     = 3'd5
    } state_t;

`ifdef LCD_INIT_EN
    localparam state_t           RST_STATE = PWR_WAIT;
    localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(POWERON_CYC - 32'd1);
`else
    localparam state_t           RST_STATE = IDLE;
    localparam logic [CNT_W-1:0] CNT_RST   = CNT_ZERO;
`endif

    // Clear display (01h) and return home (02h/03h) need the long wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) &&
               ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
    endfunction

`ifdef LCD_INIT_EN
    // Power-on sequence: 8-bit bus/2 lines, display on, clear, entry mode.
    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h38;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h01;
            2'd3:    b = 8'h06;
            default: b = 8'h38;
        endcase
        return b;
    endfunction
`endif

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] exec_load_s;
    logic             ready_r;
    logic             on_r;
    logic             en_r;
    logic             rs_r;
    logic [7:0]       data_r;
`ifdef LCD_INIT_EN
    logic [1:0]       init_idx_r;
    logic             init_busy_r;
`endif

    // Execution wait length chosen from the byte currently on the bus.
    always_comb begin
        exec_load_s = LD_EXEC;
        if (is_slow_cmd(rs_r, data_r)) begin
            exec_load_s = LD_CLEAR;
        end else begin
            exec_load_s = LD_EXEC;
        end
    end

    // Transfer sequencer: one down-counter reloaded on every state entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= RST_STATE;
            cnt_r       <= CNT_RST;
            ready_r     <= 1'b0;
            on_r        <= 1'b0;
            en_r        <= 1'b0;
            rs_r        <= 1'b0;
            data_r      <= 8'h00;
`ifdef LCD_INIT_EN
            init_idx_r  <= 2'd0;
            init_busy_r <= 1'b1;
`endif
        end else begin
            on_r <= 1'b1;
            case (state_r)
`ifdef LCD_INIT_EN
                PWR_WAIT: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= INIT;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                INIT: begin
                    rs_r    <= 1'b0;
                    data_r  <= init_byte(init_idx_r);
                    cnt_r   <= LD_SETUP;
                    state_r <= SETUP;
                end
`endif
                IDLE: begin
                    // ready_r is part of the handshake, so the first IDLE
                    // cycle after reset only raises ready.
                    if (cmd_valid_i && ready_r) begin
                        rs_r    <= cmd_rs_i;
                        data_r  <= cmd_data_i;
                        ready_r <= 1'b0;
                        cnt_r   <= LD_SETUP;
                        state_r <= SETUP;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_r == CNT_ZERO) begin
                        en_r    <= 1'b1;
                        cnt_r   <= LD_EN;
                        state_r <= PULSE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                PULSE: begin
                    if (cnt_r == CNT_ZERO) begin
                        en_r    <= 1'b0;
                        cnt_r   <= exec_load_s;
                        state_r <= EXEC;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                EXEC: begin
                    if (cnt_r == CNT_ZERO) begin
                        cnt_r <= CNT_ZERO;
`ifdef LCD_INIT_EN
                        if (init_busy_r) begin
                            if (init_idx_r == 2'd3) begin
                                init_busy_r <= 1'b0;
                                ready_r     <= 1'b1;
                                state_r     <= IDLE;
                            end else begin
                                init_idx_r <= init_idx_r + 2'd1;
                                state_r    <= INIT;
                            end
                        end else begin
                            ready_r <= 1'b1;
                            state_r <= IDLE;
                        end
`else
                        ready_r <= 1'b1;
                        state_r <= IDLE;
`endif
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    // Unreachable encodings: park safely with EN low.
                    en_r    <= 1'b0;
                    ready_r <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = ready_r;
    assign lcd_on_o    = on_r;
    assign lcd_en_o    = en_r;
    assign lcd_rs_o    = rs_r;
    assign lcd_rw_o    = 1'b0;
    assign lcd_data_o  = data_r;

endmodule

// File: tb/tb_lcd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_ctrl
// Scoreboard bench for lcd_ctrl. The stimulus process issues random writes and,
// for every accepted handshake, pushes the expected EN pulse (bus value, rise
// and fall cycles) and the expected ready-return cycle into queues, computed
// from the timing rules. A separate monitor pops and compares whenever the DUT
// raises EN or cmd_ready. Build with +define+LCD_INIT_EN for the init variant.
// -----------------------------------------------------------------------------
module tb_lcd_ctrl;

    localparam int S = 2;
    localparam int E = 3;
    localparam int X = 5;
    localparam int C = 20;
    localparam int P = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       lcd_on;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    lcd_ctrl #(
        .SETUP_CYC   (S),
        .EN_HIGH_CYC (E),
        .EXEC_CYC    (X),
        .CLEAR_CYC   (C),
        .POWERON_CYC (P)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_rs_i    (cmd_rs),
        .cmd_data_i  (cmd_data),
        .cmd_ready_o (cmd_ready),
        .lcd_on_o    (lcd_on),
        .lcd_en_o    (lcd_en),
        .lcd_rs_o    (lcd_rs),
        .lcd_rw_o    (lcd_rw),
        .lcd_data_o  (lcd_data)
    );

    always #5 clk = ~clk;

    // Rising-edge index; an event at edge k is seen at the following negedge with cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        bit         timed;
        bit         rs;
        logic [7:0] data;
        int         rise;
        int         fall;
    } pulse_t;

    pulse_t exp_q[$];
    int     rdy_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, cyc);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event not expected by model (edge %0d)", name, cyc);
    endtask

    // Execution wait rule: clear/home instructions are slow.
    function automatic int wait_for(input bit rs, input logic [7:0] d);
        if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return C;
        return X;
    endfunction

    // Handshake at edge k.
    task automatic model_accept(input int k, input bit rs, input logic [7:0] d);
        pulse_t p;
        p.timed = 1'b1;
        p.rs    = rs;
        p.data  = d;
        p.rise  = k + S;
        p.fall  = k + S + E;
        exp_q.push_back(p);
        rdy_q.push_back(k + S + E + wait_for(rs, d));
    endtask

    // Reset released after edge rel.
    task automatic model_reset(input int rel);
`ifdef LCD_INIT_EN
        logic [7:0] seq [4];
        int t;
        pulse_t p;
        seq[0] = 8'h38; seq[1] = 8'h0C; seq[2] = 8'h01; seq[3] = 8'h06;
        t = rel + P;
        for (int i = 0; i < 4; i++) begin
            p.timed = 1'b0;
            p.rs    = 1'b0;
            p.data  = seq[i];
            p.rise  = 0;
            p.fall  = 0;
            exp_q.push_back(p);
            t = t + 1 + S + E + wait_for(1'b0, seq[i]);
        end
        rdy_q.push_back(t);
`else
        rdy_q.push_back(rel + 1);
`endif
    endtask

    task automatic rand_cmd();
        case ($urandom_range(0, 5))
            0:       cmd_data = 8'h01;
            1:       cmd_data = 8'h02;
            2:       cmd_data = 8'h03;
            3:       cmd_data = 8'h38;
            default: cmd_data = 8'($urandom);
        endcase
        cmd_rs = 1'($urandom);
    endtask

    // Entered and left at a negedge; holds valid until accepted.
    task automatic send(input bit rnd, input bit rs, input logic [7:0] d);
        int waited = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (rnd) rand_cmd();
        else begin
            cmd_rs   = rs;
            cmd_data = d;
        end
        cmd_valid = 1'b1;
        forever begin
            if (cmd_ready) begin
                model_accept(cyc + 1, cmd_rs, cmd_data);
                break;
            end
            if (waited > 600) begin
                fail_now("accept_timeout");
                break;
            end
            waited++;
            @(negedge clk);
            // Busy-period churn: only the value present when ready is seen may be captured.
            if (rnd && $urandom_range(0, 1) == 1) rand_cmd();
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
    endtask

    // Monitor: compares every EN pulse and ready rise against the queues.
    initial begin : monitor
        bit     prev_en  = 1'b0;
        bit     prev_rdy = 1'b0;
        bit     have     = 1'b0;
        bit     stable   = 1'b1;
        int     rise_at  = 0;
        pulse_t cur;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en  = 1'b0;
                prev_rdy = 1'b0;
                have     = 1'b0;
            end else begin
                if (lcd_en && !prev_en) begin
                    rise_at = cyc;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_en_pulse");
                        have = 1'b0;
                    end else begin
                        cur    = exp_q.pop_front();
                        have   = 1'b1;
                        stable = 1'b1;
                        if (cur.timed) check("en_rise_edge", rise_at, cur.rise);
                        check("pulse_rs", {31'd0, lcd_rs}, {31'd0, cur.rs});
                        check("pulse_data", {24'd0, lcd_data}, {24'd0, cur.data});
                        check("rw_low", {31'd0, lcd_rw}, 32'd0);
                    end
                end
                if (lcd_en && have && (lcd_rs !== cur.rs || lcd_data !== cur.data)) stable = 1'b0;
                if (!lcd_en && prev_en && have) begin
                    check("en_high_len", cyc - rise_at, E);
                    if (cur.timed) check("en_fall_edge", cyc, cur.fall);
                    check("bus_stable_en", {31'd0, stable}, 32'd1);
                    check("bus_hold_after_fall", {23'd0, lcd_rs, lcd_data}, {23'd0, cur.rs, cur.data});
                    have = 1'b0;
                end
                if (cmd_ready && !prev_rdy) begin
                    if (rdy_q.size() == 0) fail_now("unexpected_ready_rise");
                    else check("ready_rise_edge", cyc, rdy_q.pop_front());
                    check("lcd_on_high", {31'd0, lcd_on}, 32'd1);
                end
                prev_en  = lcd_en;
                prev_rdy = cmd_ready;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd0);
        check({tag, "_on"},    {31'd0, lcd_on},    32'd0);
        check({tag, "_en"},    {31'd0, lcd_en},    32'd0);
        check({tag, "_rs"},    {31'd0, lcd_rs},    32'd0);
        check({tag, "_rw"},    {31'd0, lcd_rw},    32'd0);
        check({tag, "_data"},  {24'd0, lcd_data},  32'd0);
    endtask

    // Reset asserted while EN is high; entered and left at a negedge.
    task automatic reset_mid_pulse();
        int waited = 0;
        send(1'b0, 1'b1, 8'h5A);
        while (!lcd_en && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("en_before_reset", {31'd0, lcd_en}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        rdy_q.delete();
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        model_reset(cyc);
        @(negedge clk);
    endtask

    initial begin : stimulus
        int waited = 0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        #1;
        rst_n = 1'b1;
        model_reset(cyc);
        @(negedge clk);
        check("on_after_release", {31'd0, lcd_on}, 32'd1);
`ifdef LCD_INIT_EN
        check("ready_low_pwr_wait", {31'd0, cmd_ready}, 32'd0);
`else
        check("ready_after_release", {31'd0, cmd_ready}, 32'd1);
`endif
        send(1'b0, 1'b1, 8'h41);
        send(1'b0, 1'b0, 8'h01);
        send(1'b0, 1'b0, 8'h38);
        for (int t = 0; t < 30; t++) begin
            if (t == 15) reset_mid_pulse();
            send(1'b1, 1'b0, 8'h00);
        end
        while ((exp_q.size() != 0 || rdy_q.size() != 0) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("drain_pulses_left", exp_q.size(), 32'd0);
        check("drain_ready_left", rdy_q.size(), 32'd0);
        check("final_ready", {31'd0, cmd_ready}, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
